dsd_decimator: RTL

DSD_DECIMATOR -- requirements
Module: dsd_decimator

---
 rtl/dsd_decimator.sv | 114 +++++++++++
 1 files changed

// File: rtl/dsd_decimator.sv
// rtl/dsd_decimator.sv - 3rd-order CIC DSD-to-PCM decimator (optional output saturation via DSD_DECIM_SAT_EN)
module dsd_decimator #(
  parameter int DECIM = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               din,
  input  logic               din_en,
  output logic signed [15:0] pcm,
  output logic               pcm_valid
);

  localparam int L  = $clog2(DECIM);
  localparam int W  = 2 + 3 * L;
  localparam int SH = 3 * L - 15;

  logic [L-1:0]        r_cnt;
  logic signed [W-1:0] r_int1, r_int2, r_int3;
  logic signed [W-1:0] r_comb_in;
  logic signed [W-1:0] r_d1, r_d2, r_d3;
  logic                r_cap;
  logic                r_comb_go;

  logic signed [W-1:0] w_x;
  logic signed [W-1:0] w_int1_n, w_int2_n, w_int3_n;
  logic signed [W-1:0] w_c1, w_c2, w_c3;
  logic signed [16:0]  w_scaled;
  logic signed [15:0]  w_pcm_n;

  // din=0 is +1, din=1 is -1 (all ones in two's complement)
  assign w_x      = din ? '1 : W'(1);
  assign w_int1_n = r_int1 + w_x;
  assign w_int2_n = r_int2 + w_int1_n;
  assign w_int3_n = r_int3 + w_int2_n;

  assign w_c1 = r_comb_in - r_d1;
  assign w_c2 = w_c1 - r_d2;
  assign w_c3 = w_c2 - r_d3;

  // Comb gain is DECIM^3; bring it to a 17-bit value whose +/-2^15 spans full scale
  generate
    if (SH >= 0) begin : g_shr
      assign w_scaled = 17'(w_c3 >>> SH);
    end else begin : g_shl
      assign w_scaled = 17'(w_c3) <<< (-SH);
    end
  endgenerate

`ifdef DSD_DECIM_SAT_EN
  // Symmetric clamp to +/-32767, purely combinational so latency is unchanged
  always_comb begin
    w_pcm_n = 16'(w_scaled);
    if (w_scaled > 17'sd32767) begin
      w_pcm_n = 16'sd32767;
    end else if (w_scaled < -17'sd32767) begin
      w_pcm_n = -16'sd32767;
    end
  end
`else
  assign w_pcm_n = 16'(w_scaled);
`endif

  // Input-rate integrators and decimation counter advance only on accepted bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_int1 <= '0;
      r_int2 <= '0;
      r_int3 <= '0;
      r_cnt  <= '0;
      r_cap  <= 1'b0;
    end else begin
      r_cap <= din_en && (r_cnt == '1);
      if (din_en) begin
        r_int1 <= w_int1_n;
        r_int2 <= w_int2_n;
        r_int3 <= w_int3_n;
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  // Capture the last integrator one edge after the frame's final bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_comb_in <= '0;
      r_comb_go <= 1'b0;
    end else begin
      r_comb_go <= r_cap;
      if (r_cap) begin
        r_comb_in <= r_int3;
      end
    end
  end

  // Output-rate combs and registered PCM strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d1      <= '0;
      r_d2      <= '0;
      r_d3      <= '0;
      pcm       <= '0;
      pcm_valid <= 1'b0;
    end else begin
      pcm_valid <= r_comb_go;
      if (r_comb_go) begin
        r_d1 <= r_comb_in;
        r_d2 <= w_c1;
        r_d3 <= w_c2;
        pcm  <= w_pcm_n;
      end
    end
  end

endmodule
